bfm_alu: RTL and testbench
==========================

# bfm_alu

Pipelined two-operand arithmetic unit (RTL module `bfm_alu`) that consumes one operand pair (`A_s`, `B_s`) every clock and presents a registered result on `res_o` after a fixed latency. It sits behind the stimulus wrapper, which streams byte pairs into it unconditionally each cycle. There is no handshake, so every clock edge outside reset is a valid transaction.

## Interface

- `WIDTH`, default 8: operand and result width in bits.
- `OP`, default 0: operation select. 0 = ADD, 1 = SUB (A−B), 2 = XOR, 3 = MUL_LO (low WIDTH bits of A×B), 4 = MAX (unsigned).
- `SAT`, default 0: 1 = saturate ADD/SUB to the unsigned range; 0 = wrap modulo 2^WIDTH.
- `LATENCY`, default 2: register stages from operand sample to `res_o`. Legal range 1..4.

Ports:

- `clk_i`, in, 1: single clock. All state updates on the rising edge.
- `reset_i`, in, 1: reset is asynchronous and active-low.
- `A_s`, in, WIDTH: operand A, sampled every rising edge.
- `B_s`, in, WIDTH: operand B, sampled every rising edge.
- `res_o`, out, WIDTH: registered result.

## Operation

- Stage 0 registers `A_s` and `B_s`.
- The result is computed combinationally from the stage-0 registers.
- Stages 1..LATENCY−1 delay the result.
- `res_o` is the last stage register.
- ADD:
  - SAT=0: `(A+B) mod 2^WIDTH`.
  - SAT=1: clamp to `2^WIDTH−1` when the carry out is set.
- SUB:
  - SAT=0: `(A−B) mod 2^WIDTH`.
  - SAT=1: clamp to 0 when A<B.
- XOR: bitwise.
- MUL_LO: compute the full 2·WIDTH product internally and output the low WIDTH bits. SAT has no effect.
- MAX: the unsigned greater of A and B. Equal operands return A.
- An `OP` value outside 0..4 behaves as ADD.
- All arithmetic is unsigned. There are no status outputs.

## Timing

- Asserting `reset_i` low clears every pipeline register, including `res_o`, to 0 immediately, independent of the clock.
- Deassertion is synchronized by a two-flop release.
  - Pipeline registers stay cleared through the first rising edge after `reset_i` goes high.
  - Sampling resumes on the second edge.
- Latency: operands present before rising edge N appear on `res_o` immediately after edge N+LATENCY−1. With LATENCY=2, a result is visible one cycle after sampling.
- Full throughput: one new result per cycle, back-to-back, with no bubbles.
- Operand changes between edges have no effect. Only edge-sampled values matter.
- Reset asserted mid-stream discards all in-flight results. After release, `res_o` stays 0 until the first post-reset pair emerges.

## Structure

- Shared package `bfm_pkg` holds:
  - the operation-code constants (`OP_ADD`..`OP_MAX`);
  - a `result_t` typedef of width WIDTH;
  - an `alu_op` function used by both RTL and the scoreboard model.
- Sub-module `bfm_pipe`: a parameterized WIDTH × DEPTH delay line with async clear, instantiated for the result stages.
- Top-level `bfm_alu` contains the input registers, the reset synchronizer, the operation mux and saturation logic.

## Test plan

- Reset: hold `reset_i`=0 while driving A=0x55, B=0x11 -> `res_o`=0x00. On release, the first result is 0x66, two edges after the synchronizer release.
- ADD wrap (SAT=0): A=0xF0, B=0x20 -> 0x10. With SAT=1 the same pair -> 0xFF.
- SUB (SAT=1): A=0x05, B=0x09 -> 0x00. With SAT=0 -> 0xFC.
- MUL_LO: A=0x12, B=0x34 -> 0xA8 (full product 0x03A8). XOR: A=0xAA, B=0x0F -> 0xA5.
- Back-to-back stream of 100 random pairs, OP=ADD: `res_o` must match the package model for every pair at exactly LATENCY cycles, with no gaps.
- Reset pulse mid-stream at cycle 50: `res_o` goes 0 within the same cycle. No pre-reset pair may appear afterward, and the stream resumes correctly.

Source files
------------

// File: rtl/bfm_pkg.sv
// Shared definitions for the bfm_alu block: op codes, result type and the
// reference operation function used by both the datapath and its model.
package bfm_pkg;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_XOR = 2;
  localparam int unsigned OP_MUL = 3;
  localparam int unsigned OP_MAX = 4;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned MAX_W  = 32;
  localparam int unsigned PROD_W = 2 * MAX_W;

  typedef logic [DATA_W-1:0] result_t;

  // Unsigned op on the low 'width' bits; MUL keeps the full product before masking.
  function automatic logic [MAX_W-1:0] alu_op(input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b,
                                              input int unsigned      width,
                                              input int unsigned      op,
                                              input logic             sat);
    logic [PROD_W-1:0] mask;
    logic [PROD_W-1:0] wa;
    logic [PROD_W-1:0] wb;
    logic [PROD_W-1:0] r;
    mask = (PROD_W'(1) << width) - PROD_W'(1);
    wa   = PROD_W'(a) & mask;
    wb   = PROD_W'(b) & mask;
    case (op)
      OP_SUB:  r = (sat && (wa < wb)) ? '0 : (wa - wb);
      OP_XOR:  r = wa ^ wb;
      OP_MUL:  r = wa * wb;
      OP_MAX:  r = (wb > wa) ? wb : wa;
      default: begin
        r = wa + wb;
        if (sat && (r > mask)) r = mask;
      end
    endcase
    return MAX_W'(r & mask);
  endfunction

endpackage

// File: rtl/bfm_alu_if.sv
// Operand/result bundle between the stimulus wrapper and bfm_alu.
interface bfm_alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] A_s;
  logic [WIDTH-1:0] B_s;
  logic [WIDTH-1:0] res_o;

  modport master (output A_s, output B_s, input  res_o);
  modport slave  (input  A_s, input  B_s, output res_o);
endinterface

// File: rtl/bfm_pipe.sv
// WIDTH x DEPTH delay line with async clear and a synchronous flush.
module bfm_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_d;
  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  always_comb begin
    stage_d = '0;
    if (!flush_i) begin
      stage_d[0] = d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stage_q <= '0;
    else         stage_q <= stage_d;
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bfm_alu.sv
// Pipelined two-operand unsigned ALU: operand registers, reset release,
// operation/saturation logic and a result delay line ending in res_o.
module bfm_alu
  import bfm_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned OP      = 0,
  parameter int unsigned SAT     = 0,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] A_s,
  input  logic [WIDTH-1:0] B_s,
  output logic [WIDTH-1:0] res_o
);

  localparam int unsigned PIPE_D = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam logic        SAT_EN = (SAT != 0);

  logic             run_d;
  logic             run_q;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res_d;

  // Release flop: the pipeline holds its cleared state on the first edge after
  // reset_i rises and the operand stage captures again on the second.
  always_comb begin
    run_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) run_q <= 1'b0;
    else          run_q <= run_d;
  end

  if (LATENCY > 1) begin : g_in_reg
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    always_comb begin
      a_d = '0;
      b_d = '0;
      if (run_q) begin
        a_d = A_s;
        b_d = B_s;
      end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end

    assign opa = a_q;
    assign opb = b_q;
  end else begin : g_in_direct
    // Single-stage build registers the result straight from the input pins.
    assign opa = A_s;
    assign opb = B_s;
  end

  always_comb begin
    res_d = WIDTH'(alu_op(MAX_W'(opa), MAX_W'(opb), WIDTH, OP, SAT_EN));
  end

  bfm_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (PIPE_D)
  ) u_pipe (
    .clk_i   (clk_i),
    .rst_ni  (reset_i),
    .flush_i (!run_q),
    .d_i     (res_d),
    .q_o     (res_o)
  );

endmodule

// File: tb/tb_bfm_alu.sv
// Scoreboard bench for bfm_alu across op/sat/latency variants sharing one operand stream.
module tb_bfm_alu;
  import bfm_pkg::*;

  localparam int unsigned N_DUT = 9;
  localparam int unsigned CFG_OP  [N_DUT] = '{0, 0, 1, 1, 2, 3, 4, 0, 7};
  localparam int unsigned CFG_SAT [N_DUT] = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
  localparam int unsigned CFG_LAT [N_DUT] = '{2, 2, 2, 2, 2, 2, 2, 1, 4};

  typedef logic [N_DUT-1:0][DATA_W-1:0] expv_t;
  typedef struct packed {
    int    s;
    logic  live;
    expv_t exp;
  } sb_t;

  logic  clk_i = 1'b0;
  logic  reset_i;
  logic  run_m;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  expv_t res_all;
  sb_t   sb_q[$];

  always #5 clk_i = ~clk_i;

  bfm_alu_if #(.WIDTH(DATA_W)) alu_if ();

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    bfm_alu #(
      .WIDTH   (DATA_W),
      .OP      (CFG_OP[g]),
      .SAT     (CFG_SAT[g]),
      .LATENCY (CFG_LAT[g])
    ) u_dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .A_s     (alu_if.A_s),
      .B_s     (alu_if.B_s),
      .res_o   (res_all[g])
    );
  end

  assign alu_if.res_o = res_all[0];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Expected release behaviour: sampling is live from the second edge after reset_i rises.
  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) run_m <= 1'b0;
    else          run_m <= 1'b1;
  end

  function automatic result_t dut_out(input int d);
    return (d == 0) ? alu_if.res_o : res_all[d];
  endfunction

  task automatic check(input string name, input int d, input result_t got, input result_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%02h expected=%02h", name, d, cyc, got, exp);
    end
  endtask

  // Monitor: each DUT shows the entry sampled LAT-1 edges ago, or 0 if none/discarded.
  always @(negedge clk_i) begin
    for (int d = 0; d < N_DUT; d++) begin
      int      s;
      result_t exp;
      s   = cyc - int'(CFG_LAT[d]) + 1;
      exp = '0;
      foreach (sb_q[i]) begin
        if (sb_q[i].s == s && sb_q[i].live) exp = sb_q[i].exp[d];
      end
      check("stream", d, dut_out(d), exp);
    end
    while (sb_q.size() > 0 && (sb_q[0].s + 3) <= cyc) void'(sb_q.pop_front());
  end

  task automatic step(input result_t a, input result_t b, input logic rst_v, input expv_t exp);
    sb_t e;
    @(negedge clk_i);
    reset_i    = rst_v;
    alu_if.A_s = a;
    alu_if.B_s = b;
    e.s    = cyc + 1;
    e.live = rst_v && run_m;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Hand-computed results: add, add_sat, sub, sub_sat, xor, mul_lo, max.
  task automatic dir(input result_t a, input result_t b, input result_t add, input result_t adds,
                     input result_t sub, input result_t subs, input result_t xr,
                     input result_t mul, input result_t mx, input logic rst_v);
    expv_t e;
    e[0] = add;  e[1] = adds; e[2] = sub; e[3] = subs; e[4] = xr;
    e[5] = mul;  e[6] = mx;   e[7] = add; e[8] = add;
    step(a, b, rst_v, e);
  endtask

  task automatic rand_step(input logic rst_v);
    result_t a;
    result_t b;
    expv_t   e;
    a = result_t'($urandom);
    b = result_t'($urandom);
    for (int d = 0; d < N_DUT; d++) begin
      e[d] = result_t'(alu_op(MAX_W'(a), MAX_W'(b), DATA_W, CFG_OP[d], CFG_SAT[d] != 0));
    end
    step(a, b, rst_v, e);
  endtask

  task automatic mid_reset();
    @(posedge clk_i);
    #2;
    reset_i = 1'b0;
    #1;
    for (int d = 0; d < N_DUT; d++) check("reset_async", d, dut_out(d), '0);
    foreach (sb_q[i]) sb_q[i].live = 1'b0;
  endtask

  initial begin
    reset_i    = 1'b1;
    alu_if.A_s = '0;
    alu_if.B_s = '0;
    #1 reset_i = 1'b0;

    repeat (3) dir(8'h55, 8'h11, 8'h66, 8'h66, 8'h44, 8'h44, 8'h44, 8'hA5, 8'h55, 1'b0);
    repeat (3) dir(8'h55, 8'h11, 8'h66, 8'h66, 8'h44, 8'h44, 8'h44, 8'hA5, 8'h55, 1'b1);
    dir(8'hF0, 8'h20, 8'h10, 8'hFF, 8'hD0, 8'hD0, 8'hD0, 8'h00, 8'hF0, 1'b1);
    dir(8'h05, 8'h09, 8'h0E, 8'h0E, 8'hFC, 8'h00, 8'h0C, 8'h2D, 8'h09, 1'b1);
    dir(8'h12, 8'h34, 8'h46, 8'h46, 8'hDE, 8'h00, 8'h26, 8'hA8, 8'h34, 1'b1);
    dir(8'hAA, 8'h0F, 8'hB9, 8'hB9, 8'h9B, 8'h9B, 8'hA5, 8'hF6, 8'hAA, 1'b1);
    dir(8'h7F, 8'h7F, 8'hFE, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h01, 8'h7F, 1'b1);
    dir(8'hFF, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 1'b1);
    dir(8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1);

    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        mid_reset();
        rand_step(1'b0);
        rand_step(1'b0);
      end
      rand_step(1'b1);
    end

    repeat (6) dir(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    @(negedge clk_i);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
